// File: rtl/ctrl_sequencer.sv
// Hardwired control unit for the Mini SRC datapath: fetch, then execute
// register-register / immediate ALU instructions, nop and halt.
module ctrl_sequencer #(
  parameter logic [4:0]  ALU_ADD   = 5'b00011,
  parameter logic [4:0]  ALU_SUB   = 5'b00100,
  parameter logic [4:0]  ALU_AND   = 5'b01010,
  parameter logic [4:0]  ALU_OR    = 5'b01011,
  parameter logic [4:0]  ALU_INCPC = 5'b11111,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             pc_out,
  output logic             mar_en,
  output logic             zlo_en,
  output logic             zlo_out,
  output logic             pc_en,
  output logic             read,
  output logic             mdr_en,
  output logic             mdr_out,
  output logic             ir_en,
  output logic             y_en,
  output logic             c_out,
  output logic [4:0]       alu_control,
  output logic [15:0]      r_out,
  output logic [15:0]      r_en,
  output logic             run,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET = 4'b0000,
    S_T0    = 4'b0111,
    S_T1    = 4'b1000,
    S_T2    = 4'b1001,
    S_T3    = 4'b1010,
    S_T4    = 4'b1011,
    S_T5    = 4'b1100,
    S_HALT  = 4'b1111
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;

  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_is_r;
  logic       w_is_i;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign w_ra        = ir[26:23];
  assign w_rb        = ir[22:19];
  assign w_rc        = ir[18:15];
  assign w_unused_ir = ^ir[14:0];
  assign w_is_r      = (w_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR});
  assign w_is_i      = (w_op inside {OP_ADDI, OP_ANDI, OP_ORI});

  assign state       = r_state;
  assign instr_count = r_cnt;

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_RESET;
    else      r_state <= w_next;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)          r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
  end

  // Next-state and Moore strobe decode
  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    pc_out      = 1'b0;
    mar_en      = 1'b0;
    zlo_en      = 1'b0;
    zlo_out     = 1'b0;
    pc_en       = 1'b0;
    read        = 1'b0;
    mdr_en      = 1'b0;
    mdr_out     = 1'b0;
    ir_en       = 1'b0;
    y_en        = 1'b0;
    c_out       = 1'b0;
    alu_control = 5'b00000;
    r_out       = 16'h0000;
    r_en        = 16'h0000;
    run         = 1'b1;

    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0: begin
        pc_out      = 1'b1;
        mar_en      = 1'b1;
        zlo_en      = 1'b1;
        alu_control = ALU_INCPC;
        w_next      = S_T1;
      end
      S_T1: begin
        // Stalling here just reloads PC with the same Z value
        zlo_out = 1'b1;
        pc_en   = 1'b1;
        read    = 1'b1;
        mdr_en  = 1'b1;
        if (mem_ready) w_next = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_en   = 1'b1;
        w_next  = S_T3;
      end
      S_T3: begin
        if (w_is_r || w_is_i) begin
          r_out  = 16'(1) << w_rb;
          y_en   = 1'b1;
          w_next = S_T4;
        end else if (w_op == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          w_next   = S_T0;
          w_retire = 1'b1;
        end
      end
      S_T4: begin
        zlo_en = 1'b1;
        if (w_is_i) c_out = 1'b1;
        else        r_out = 16'(1) << w_rc;
        case (w_op)
          OP_ADD, OP_ADDI: alu_control = ALU_ADD;
          OP_SUB:          alu_control = ALU_SUB;
          OP_AND, OP_ANDI: alu_control = ALU_AND;
          OP_OR, OP_ORI:   alu_control = ALU_OR;
          default:         alu_control = 5'b00000;
        endcase
        w_next = S_T5;
      end
      S_T5: begin
        zlo_out  = 1'b1;
        r_en     = 16'(1) << w_ra;
        w_next   = S_T0;
        w_retire = 1'b1;
      end
      S_HALT: begin
        run    = 1'b0;
        w_next = S_HALT;
      end
      default: w_next = S_RESET;
    endcase
  end

endmodule
